// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared types and elaboration helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Ceiling log2, usable in localparam expressions to size the step counter.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/product handshake bundle between the operand source, the multiplier and the result sink.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/seq_shift_add_multiplier_cond_negate.sv
// Combinational two's-complement negate when enabled; negating zero yields zero.
module cond_negate #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic         en,
  output logic [W-1:0] y
);

  assign y = en ? (~x + W'(1)) : x;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential radix-2 shift-add multiplier: one partial product per cycle,
// operands and product exchanged through valid/ready handshakes.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input logic                     clk,
  input logic                     rst,
  seq_shift_add_multiplier_if.slave bus
);

  localparam int              CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mult_state_t        state;
  mult_state_t        state_next;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc_hi;
  logic [CNT_W-1:0]   count;
  logic               sign;
  logic [2*WIDTH-1:0] product_q;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] result;
  logic               accept;
  logic               last_step;

  // Operands are reduced to magnitudes; the WIDTH-bit negate of -2^(WIDTH-1) is exactly its magnitude.
  assign a_neg = SIGNED & bus.a[WIDTH-1];
  assign b_neg = SIGNED & bus.b[WIDTH-1];

  cond_negate #(.W(WIDTH)) u_neg_a (
    .x  (bus.a),
    .en (a_neg),
    .y  (a_mag)
  );

  cond_negate #(.W(WIDTH)) u_neg_b (
    .x  (bus.b),
    .en (b_neg),
    .y  (b_mag)
  );

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_step = (state == RUN) && (count == LAST);

  // Carry out of the upper-half add is kept and shifted down into the accumulator.
  assign sum     = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign shifted = {sum, mplier[WIDTH-1:1]};

  cond_negate #(.W(2*WIDTH)) u_neg_p (
    .x  (shifted),
    .en (sign),
    .y  (result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last_step)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE:    bus.in_ready  = 1'b1;
      RUN:     bus.busy      = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  // Final step registers the sign-corrected product directly, so DONE presents it with no extra cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc_hi    <= '0;
      count     <= '0;
      sign      <= 1'b0;
      product_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc_hi <= '0;
            count  <= '0;
            sign   <= a_neg ^ b_neg;
          end
        end
        RUN: begin
          acc_hi <= shifted[2*WIDTH-1:WIDTH];
          mplier <= shifted[WIDTH-1:0];
          count  <= count + 1'b1;
          if (last_step) product_q <= result;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: three multiplier instances (2-bit unsigned, 8-bit unsigned, 8-bit signed)
// checked against an arithmetic reference model with directed and randomized traffic.
module tb_seq_shift_add_multiplier;

  logic clk;
  logic rst;
  int   tests;
  int   failures;

  seq_shift_add_multiplier_if #(.WIDTH(2)) if2 ();
  seq_shift_add_multiplier_if #(.WIDTH(8)) if8u ();
  seq_shift_add_multiplier_if #(.WIDTH(8)) if8s ();

  seq_shift_add_multiplier #(.WIDTH(2), .SIGNED(1'b0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  seq_shift_add_multiplier #(.WIDTH(8), .SIGNED(1'b0)) dut8u (
    .clk (clk),
    .rst (rst),
    .bus (if8u)
  );

  seq_shift_add_multiplier #(.WIDTH(8), .SIGNED(1'b1)) dut8s (
    .clk (clk),
    .rst (rst),
    .bus (if8s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int width_of(input int sel);
    return (sel == 0) ? 2 : 8;
  endfunction

  function automatic bit signed_of(input int sel);
    return sel == 2;
  endfunction

  // Reference: plain integer multiplication of the operands as interpreted at this width/signedness.
  function automatic logic [15:0] ref_product(input int sel, input logic [7:0] a, input logic [7:0] b);
    longint ai, bi, p, mask;
    int w;
    w = width_of(sel);
    if (signed_of(sel)) begin
      ai = longint'($signed(a));
      bi = longint'($signed(b));
    end else begin
      ai = longint'(a) & ((64'sd1 <<< w) - 1);
      bi = longint'(b) & ((64'sd1 <<< w) - 1);
    end
    p    = ai * bi;
    mask = (64'sd1 <<< (2 * w)) - 1;
    return 16'(p & mask);
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [7:0] a, input logic [7:0] b);
    case (sel)
      0: begin if2.in_valid = v;  if2.a = a[1:0]; if2.b = b[1:0]; end
      1: begin if8u.in_valid = v; if8u.a = a;     if8u.b = b;     end
      default: begin if8s.in_valid = v; if8s.a = a; if8s.b = b; end
    endcase
  endtask

  task automatic set_out_ready(input int sel, input logic r);
    case (sel)
      0:       if2.out_ready  = r;
      1:       if8u.out_ready = r;
      default: if8s.out_ready = r;
    endcase
  endtask

  function automatic logic get_in_ready(input int sel);
    case (sel)
      0:       return if2.in_ready;
      1:       return if8u.in_ready;
      default: return if8s.in_ready;
    endcase
  endfunction

  function automatic logic get_out_valid(input int sel);
    case (sel)
      0:       return if2.out_valid;
      1:       return if8u.out_valid;
      default: return if8s.out_valid;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return if2.busy;
      1:       return if8u.busy;
      default: return if8s.busy;
    endcase
  endfunction

  function automatic logic [15:0] get_product(input int sel);
    case (sel)
      0:       return {12'h000, if2.product};
      1:       return if8u.product;
      default: return if8s.product;
    endcase
  endfunction

  task automatic check_reset_values(input int sel, input string tag);
    checkOutput({tag, "_in_ready"},  32'(get_in_ready(sel)),  32'd1);
    checkOutput({tag, "_out_valid"}, 32'(get_out_valid(sel)), 32'd0);
    checkOutput({tag, "_busy"},      32'(get_busy(sel)),      32'd0);
    checkOutput({tag, "_product"},   32'(get_product(sel)),   32'd0);
  endtask

  // One complete transaction with an always-ready sink; checks latency, product and return to IDLE.
  task automatic applyStimulus(input int sel, input logic [7:0] a, input logic [7:0] b,
                               output logic [15:0] prod);
    int k;
    int w;
    w = width_of(sel);
    set_out_ready(sel, 1'b1);
    @(negedge clk);
    k = 0;
    while (!get_in_ready(sel) && k < 50) begin
      @(negedge clk);
      k++;
    end
    checkOutput("start_in_ready", 32'(get_in_ready(sel)), 32'd1);
    set_in(sel, 1'b1, a, b);
    @(negedge clk);
    set_in(sel, 1'b0, 8'h00, 8'h00);
    checkOutput("run_busy", 32'(get_busy(sel)), 32'd1);
    checkOutput("run_in_ready", 32'(get_in_ready(sel)), 32'd0);
    k = 1;
    while (!get_out_valid(sel) && k < 4 * w + 8) begin
      @(negedge clk);
      k++;
    end
    checkOutput("latency", 32'(k), 32'(w + 1));
    prod = get_product(sel);
    checkOutput("product", 32'(prod), 32'(ref_product(sel, a, b)));
    checkOutput("done_busy", 32'(get_busy(sel)), 32'd0);
    @(negedge clk);
    checkOutput("release_out_valid", 32'(get_out_valid(sel)), 32'd0);
    checkOutput("release_in_ready", 32'(get_in_ready(sel)), 32'd1);
  endtask

  // Random producer/consumer with gaps on both handshakes; a queue of model results tracks order.
  task automatic randomRun(input int sel, input int n);
    logic [15:0] expq[$];
    int          sent;
    int          got;
    int          guard;
    int          extra;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        v;
    logic        r;
    sent  = 0;
    got   = 0;
    guard = 0;
    extra = 0;
    fork
      begin
        while (sent < n) begin
          @(negedge clk);
          ra = 8'($urandom);
          rb = 8'($urandom);
          v  = ($urandom_range(0, 3) != 0);
          set_in(sel, v, ra, rb);
          if (v && get_in_ready(sel)) begin
            expq.push_back(ref_product(sel, ra, rb));
            sent++;
          end
        end
        @(negedge clk);
        set_in(sel, 1'b0, 8'h00, 8'h00);
      end
      begin
        while (got < n && guard < n * 40) begin
          @(negedge clk);
          guard++;
          r = ($urandom_range(0, 3) != 0);
          set_out_ready(sel, r);
          if (get_out_valid(sel) && r) begin
            if (expq.size() == 0) begin
              checkOutput("rand_unexpected_result", 32'(expq.size()), 32'd1);
            end else begin
              checkOutput("rand_product", 32'(get_product(sel)), 32'(expq.pop_front()));
              got++;
            end
          end
        end
      end
    join
    checkOutput("rand_result_count", 32'(got), 32'(n));
    checkOutput("rand_queue_empty", 32'(expq.size()), 32'd0);
    set_out_ready(sel, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (get_out_valid(sel)) extra++;
    end
    checkOutput("rand_no_duplicate", 32'(extra), 32'd0);
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] bp_expected;
    int          k;
    int          seen_valid;

    tests    = 0;
    failures = 0;
    rst      = 1'b1;
    for (int s = 0; s < 3; s++) begin
      set_in(s, 1'b0, 8'h00, 8'h00);
      set_out_ready(s, 1'b0);
    end
    repeat (3) @(negedge clk);
    check_reset_values(0, "reset_w2");
    check_reset_values(1, "reset_w8u");
    check_reset_values(2, "reset_w8s");
    rst = 1'b0;

    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        applyStimulus(0, 8'(ia), 8'(ib), p);
        if (ia == 3 && ib == 3) checkOutput("w2_3x3", 32'(p), 32'h9);
      end
    end

    applyStimulus(1, 8'd255, 8'd255, p);
    checkOutput("w8u_255x255", 32'(p), 32'hFE01);

    applyStimulus(2, 8'hFD, 8'h05, p);
    checkOutput("w8s_m3x5", 32'(p), 32'hFFF1);
    applyStimulus(2, 8'h80, 8'h80, p);
    checkOutput("w8s_m128xm128", 32'(p), 32'h4000);
    applyStimulus(2, 8'h80, 8'h01, p);
    checkOutput("w8s_m128x1", 32'(p), 32'hFF80);
    applyStimulus(2, 8'h00, 8'hF9, p);
    checkOutput("w8s_0xm7", 32'(p), 32'h0000);

    // Backpressure: sink stalls for 20 cycles while the source keeps offering new operands.
    bp_expected = 16'hFFEB;
    set_out_ready(2, 1'b0);
    @(negedge clk);
    set_in(2, 1'b1, 8'hFD, 8'h07);
    @(negedge clk);
    set_in(2, 1'b0, 8'h00, 8'h00);
    k = 1;
    while (!get_out_valid(2) && k < 40) begin
      @(negedge clk);
      k++;
    end
    checkOutput("bp_latency", 32'(k), 32'd9);
    checkOutput("bp_product", 32'(get_product(2)), 32'(bp_expected));
    for (int i = 0; i < 20; i++) begin
      set_in(2, 1'b1, 8'($urandom), 8'($urandom));
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(get_out_valid(2)), 32'd1);
      checkOutput("bp_hold", 32'(get_product(2)), 32'(bp_expected));
      checkOutput("bp_in_ready", 32'(get_in_ready(2)), 32'd0);
    end
    set_in(2, 1'b0, 8'h00, 8'h00);
    set_out_ready(2, 1'b1);
    @(negedge clk);
    checkOutput("bp_release_valid", 32'(get_out_valid(2)), 32'd0);
    checkOutput("bp_release_ready", 32'(get_in_ready(2)), 32'd1);
    @(negedge clk);
    checkOutput("bp_no_capture", 32'(get_busy(2)), 32'd0);

    // Reset in the middle of RUN: the in-flight result must vanish.
    set_out_ready(1, 1'b1);
    set_in(1, 1'b1, 8'd200, 8'd100);
    @(negedge clk);
    set_in(1, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values(1, "midrun_w8u");
    checkOutput("midrun_w8s_product", 32'(get_product(2)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (get_out_valid(1)) seen_valid++;
    end
    checkOutput("midrun_no_out_valid", 32'(seen_valid), 32'd0);
    applyStimulus(1, 8'd7, 8'd6, p);
    checkOutput("after_reset_7x6", 32'(p), 32'd42);

    fork
      randomRun(1, 1500);
      randomRun(2, 1500);
    join

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
